spi_reg_writer: RTL

SPI_REG_WRITER -- requirements
Module: spi_reg_writer

---
 rtl/spi_regmap_pkg.sv | 32 +++
 rtl/spi_half_tick.sv | 26 ++
 rtl/spi_reg_writer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/spi_regmap_pkg.sv
// Register map and frame layout shared by the SPI register writer and anything
// that decodes its frames.
package spi_regmap_pkg;

  localparam int FRAME_W = 16;
  localparam int WR_BIT  = 15;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_7_0    = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_15_8   = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_7_0    = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_15_8   = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY_CYCLE = 7'h04;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_e;

  // Write frame: write flag, then address, then data, sent MSB first.
  function automatic logic [FRAME_W-1:0] make_frame(input logic [ADDR_W-1:0] addr,
                                                    input logic [DATA_W-1:0] data);
    logic [FRAME_W-1:0] f;
    f = {1'b1, addr, data};
    return f;
  endfunction

endpackage

// File: rtl/spi_half_tick.sv
// Free-running half-period timebase; restarting it on a new transaction keeps
// every phase of the frame exactly HALF_PERIOD clocks long.
module spi_half_tick #(
  parameter int HALF_PERIOD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  logic [7:0] cnt_q, cnt_d;

  assign tick = (cnt_q == 8'(HALF_PERIOD - 1));

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_reg_writer.sv
// Mode-0 SPI controller that turns one addr/data command into a 16-bit write
// frame; all bus outputs come straight from flops.
module spi_reg_writer
  import spi_regmap_pkg::*;
#(
  parameter int HALF_PERIOD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              done,
  output logic              sclk,
  output logic              copi,
  output logic              ncs
);

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [4:0]         bit_cnt_q, bit_cnt_d;
  logic               sclk_q, sclk_d, copi_q, copi_d, ncs_q, ncs_d;
  logic               done_q, done_d, rdy_q, rdy_d;
  logic               tick, tick_clr, accept;
  logic [FRAME_W-1:0] frame;

  assign accept = cmd_valid & rdy_q;
  assign frame  = make_frame(cmd_addr, cmd_data);

  spi_half_tick #(.HALF_PERIOD(HALF_PERIOD)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    sclk_d    = sclk_q;
    copi_d    = copi_q;
    ncs_d     = ncs_q;
    done_d    = 1'b0;
    tick_clr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ncs_d  = 1'b1;
        sclk_d = 1'b0;
        copi_d = 1'b0;
        if (accept) begin
          state_d   = ST_SETUP;
          shreg_d   = frame;
          copi_d    = frame[WR_BIT];
          ncs_d     = 1'b0;
          bit_cnt_d = '0;
          tick_clr  = 1'b1;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          state_d = ST_SHIFT;
          sclk_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (sclk_q) begin
            // Falling edge: the next bit goes out together with sclk dropping.
            sclk_d    = 1'b0;
            shreg_d   = {shreg_q[FRAME_W-2:0], 1'b0};
            copi_d    = shreg_q[FRAME_W-2];
            bit_cnt_d = bit_cnt_q + 5'd1;
          end else if (bit_cnt_q == 5'(FRAME_W)) begin
            state_d = ST_HOLD;
          end else begin
            sclk_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          state_d = ST_GAP;
          ncs_d   = 1'b1;
          copi_d  = 1'b0;
        end
      end
      ST_GAP: begin
        if (tick) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    rdy_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      sclk_q    <= 1'b0;
      copi_q    <= 1'b0;
      ncs_q     <= 1'b1;
      done_q    <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      sclk_q    <= sclk_d;
      copi_q    <= copi_d;
      ncs_q     <= ncs_d;
      done_q    <= done_d;
      rdy_q     <= rdy_d;
    end
  end

  assign cmd_ready = rdy_q;
  assign done      = done_q;
  assign sclk      = sclk_q;
  assign copi      = copi_q;
  assign ncs       = ncs_q;

endmodule
